// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants used by fetch, decode and the hazard unit.
package pipe_pkg;

    typedef logic [15:0] instr_t;

    localparam instr_t      NOP_INSTR = 16'h0800;
    localparam logic [15:0] RESET_PC  = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch: inject-NOP beats load, and neither means hold.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter instr_t      NOP_VAL   = NOP_INSTR,
    parameter logic [15:0] PC2_RESET = RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        inject_nop,
    input  instr_t      instr_in,
    input  logic [15:0] pc2_in,
    output instr_t      instr,
    output logic [15:0] pc2,
    output logic        valid
);

    // pc2 is left alone on a bubble; consumers only look at it when valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr <= NOP_VAL;
            pc2   <= PC2_RESET;
            valid <= 1'b0;
        end else if (inject_nop) begin
            instr <= NOP_VAL;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc2   <= pc2_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, imem request FSM (RUN/WAIT/HALT), one-entry redirect buffer, IF/ID latch.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_stage
    import pipe_pkg::instr_t, pipe_pkg::fetch_state_t,
           pipe_pkg::ST_RUN, pipe_pkg::ST_WAIT, pipe_pkg::ST_HALT;
#(
    parameter logic [15:0] RESET_PC  = pipe_pkg::RESET_PC,
    parameter instr_t      NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter logic [15:0] PC_INC    = 16'd2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         flush,
    input  logic         redirect_valid,
    input  logic [15:0]  redirect_pc,
    input  logic         halt_in,
    output logic         imem_rd,
    output logic [15:0]  imem_addr,
    input  instr_t       imem_rdata,
    input  logic         imem_done,
    input  logic         imem_stall,
    output logic [15:0]  pc,
    output instr_t       if_id_instr,
    output logic [15:0]  if_id_pc2,
    output logic         if_id_valid,
    output logic         fetch_stall,
    output logic         halted,
`ifdef FETCH_PERF_EN
    output logic [31:0]  perf_fetch_cnt,
    output logic [31:0]  perf_stall_cnt,
`endif
    output fetch_state_t fsm_state
);

    fetch_state_t state, state_n;
    logic [15:0]  pc_n, pend_pc, pend_pc_n, redir, pc_inc;
    logic         pend_valid, pend_valid_n, halt_pend, halt_pend_n;
    logic         rd, load, nop;

    assign redir     = {redirect_pc[15:1], 1'b0};
    assign pc_inc    = pc + PC_INC;
    assign imem_rd   = rst & rd;
    assign imem_addr = pc;
    assign fetch_stall = rst & ((state == ST_WAIT) | (rd & imem_stall));
    assign halted    = rst & (state == ST_HALT);
    assign fsm_state = state;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_valid_n = pend_valid;
        pend_pc_n    = pend_pc;
        halt_pend_n  = halt_pend;
        rd           = 1'b0;
        load         = 1'b0;
        nop          = 1'b0;
        case (state)
            ST_RUN: begin
                rd = ~hold & ~halt_in;
                if (halt_in) begin
                    state_n = ST_HALT;
                    nop     = 1'b1;
                end else if (redirect_valid) begin
                    nop = 1'b1;
                    // A request already on the bus must be drained before the PC may move.
                    if (rd && !imem_done) begin
                        state_n      = ST_WAIT;
                        pend_valid_n = 1'b1;
                        pend_pc_n    = redir;
                    end else begin
                        pc_n = redir;
                    end
                end else if (hold) begin
                    nop = flush;
                end else if (imem_done) begin
                    pc_n = pc_inc;
                    nop  = flush;
                    load = ~flush;
                end else begin
                    state_n = ST_WAIT;
                    nop     = 1'b1;
                end
            end
            ST_WAIT: begin
                rd = 1'b1;
                if (halt_in) halt_pend_n = 1'b1;
                if (redirect_valid) begin
                    pend_valid_n = 1'b1;
                    pend_pc_n    = redir;
                end
                nop = flush | redirect_valid | (~hold & ~imem_done);
                if (imem_done) begin
                    state_n      = ST_RUN;
                    pend_valid_n = 1'b0;
                    halt_pend_n  = 1'b0;
                    if (halt_pend || halt_in) begin
                        state_n = ST_HALT;
                        nop     = 1'b1;
                    end else if (redirect_valid) begin
                        pc_n = redir;
                    end else if (pend_valid) begin
                        pc_n = pend_pc;
                        if (!hold) nop = 1'b1;
                    end else if (!hold) begin
                        // Under hold the word is dropped and refetched from the same pc.
                        pc_n = pc_inc;
                        load = ~flush;
                    end
                end
            end
            ST_HALT: begin
                nop = 1'b1;
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_RUN;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= RESET_PC;
            halt_pend  <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pend_valid <= pend_valid_n;
            pend_pc    <= pend_pc_n;
            halt_pend  <= halt_pend_n;
        end
    end

    if_id_reg #(
        .NOP_VAL   (NOP_INSTR),
        .PC2_RESET (RESET_PC)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .inject_nop (nop),
        .instr_in   (imem_rdata),
        .pc2_in     (pc_inc),
        .instr      (if_id_instr),
        .pc2        (if_id_pc2),
        .valid      (if_id_valid)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (load && (perf_fetch_cnt != 32'hFFFF_FFFF))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((fetch_stall || hold) && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, corner sequences, randomized run vs. a transaction model.
module tb_fetch_stage;
    import pipe_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         hold = 1'b0, flush = 1'b0, redirect_valid = 1'b0, halt_in = 1'b0;
    logic         imem_done = 1'b0, imem_stall = 1'b0;
    logic [15:0]  redirect_pc = 16'h0, imem_rdata = 16'h0;
    logic         imem_rd, if_id_valid, fetch_stall, halted;
    logic [15:0]  imem_addr, pc, if_id_instr, if_id_pc2;
    fetch_state_t fsm_state;
`ifdef FETCH_PERF_EN
    logic [31:0]  perf_fetch_cnt, perf_stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .hold           (hold),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_in        (halt_in),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_done      (imem_done),
        .imem_stall     (imem_stall),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc2      (if_id_pc2),
        .if_id_valid    (if_id_valid),
        .fetch_stall    (fetch_stall),
        .halted         (halted),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        h, f, rv;
        logic [15:0] rpc;
        logic        hi, d;
        logic [15:0] rdata;
        logic        e_rd, e_st;
        logic [15:0] e_addr, e_pc, e_ins;
        logic        e_v, e_hl;
    } vec_t;

    vec_t vq[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    task automatic drive(input logic h, input logic f, input logic rv, input logic [15:0] rp,
                         input logic hi, input logic d, input logic [15:0] rdat);
        hold = h; flush = f; redirect_valid = rv; redirect_pc = rp;
        halt_in = hi; imem_done = d; imem_rdata = rdat;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic h, input logic f, input logic rv, input logic [15:0] rpc,
                           input logic hi, input logic d, input logic [15:0] rdata,
                           input logic e_rd, input logic e_st, input logic [15:0] e_addr,
                           input logic [15:0] e_pc, input logic [15:0] e_ins,
                           input logic e_v, input logic e_hl);
        vec_t v;
        v.h = h; v.f = f; v.rv = rv; v.rpc = rpc; v.hi = hi; v.d = d; v.rdata = rdata;
        v.e_rd = e_rd; v.e_st = e_st; v.e_addr = e_addr; v.e_pc = e_pc; v.e_ins = e_ins;
        v.e_v = e_v; v.e_hl = e_hl;
        vq.push_back(v);
    endtask

    task automatic do_reset;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        rst = 1'b0;
        #1;
        chk1("rst_cycle_rd", imem_rd, 1'b0);
        chk1("rst_cycle_stall", fetch_stall, 1'b0);
        chk1("rst_cycle_halted", halted, 1'b0);
        tick;
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        // Directed vectors, one per cycle from reset (pc=0, RUN).
        //       h     f     rv    rpc      hi    d     rdata    rd    st    addr     pc       instr    v     hl
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b0, 16'h0000, 16'h0002, 16'h1111, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2222, 1'b1, 1'b0, 16'h0002, 16'h0004, 16'h2222, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b0, 16'h0004, 16'h0006, 16'h3333, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4444, 1'b1, 1'b0, 16'h0006, 16'h0008, 16'h4444, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hABCD, 1'b1, 1'b0, 16'h0008, 16'h000A, 16'hABCD, 1'b1, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h000A, 16'h000A, 16'hABCD, 1'b1, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h000A, 16'h000A, 16'hABCD, 1'b1, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h000A, 16'h000A, 16'h0800, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 16'h000A, 16'h000C, 16'h0800, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 16'h6666, 1'b1, 1'b0, 16'h000C, 16'h0010, 16'h0800, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0010, 16'h0800, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h0010, 16'h0800, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h0010, 16'h0800, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b1, 16'h0010, 16'h0012, 16'h7777, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 16'h0012, 16'h0800, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 16'h0012, 16'h0800, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b1, 16'h0012, 16'h0100, 16'h0800, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0100, 16'h0102, 16'h1234, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 16'h0020, 1'b0, 1'b1, 16'h5678, 1'b1, 1'b0, 16'h0102, 16'h0020, 16'h0800, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h4321, 1'b0, 1'b0, 16'h0020, 16'h0020, 16'h0800, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0020, 16'h0020, 16'h0800, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 16'h0020, 16'h0020, 16'h0800, 1'b0, 1'b1);

        tick;
        do_reset;
        chk16("reset_pc", pc, 16'h0000);
        chk16("reset_instr", if_id_instr, 16'h0800);
        chk16("reset_pc2", if_id_pc2, 16'h0000);
        chk1("reset_valid", if_id_valid, 1'b0);
        chk1("reset_state_run", fsm_state == ST_RUN, 1'b1);

        foreach (vq[i]) begin
            drive(vq[i].h, vq[i].f, vq[i].rv, vq[i].rpc, vq[i].hi, vq[i].d, vq[i].rdata);
            #1;
            chk1($sformatf("v%0d_rd", i), imem_rd, vq[i].e_rd);
            chk1($sformatf("v%0d_stall", i), fetch_stall, vq[i].e_st);
            chk16($sformatf("v%0d_addr", i), imem_addr, vq[i].e_addr);
            tick;
            chk16($sformatf("v%0d_pc", i), pc, vq[i].e_pc);
            chk16($sformatf("v%0d_instr", i), if_id_instr, vq[i].e_ins);
            chk1($sformatf("v%0d_valid", i), if_id_valid, vq[i].e_v);
            chk1($sformatf("v%0d_halted", i), halted, vq[i].e_hl);
            if (vq[i].e_v) chk16($sformatf("v%0d_pc2", i), if_id_pc2, vq[i].e_pc);
        end

        // Reset is the only way out of HALT.
        do_reset;
        chk16("unhalt_pc", pc, 16'h0000);
        chk1("unhalt_halted", halted, 1'b0);

        // Sequential fetch at 0xFFFE wraps to 0x0000.
        drive(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1, 16'h0000);
        #1;
        chk1("unhalt_rd", imem_rd, 1'b1);
        tick;
        chk16("wrap_pre_pc", pc, 16'hFFFE);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
        tick;
        chk16("wrap_pc", pc, 16'h0000);
        chk16("wrap_instr", if_id_instr, 16'hBEEF);
        chk16("wrap_pc2", if_id_pc2, 16'h0000);
        chk1("wrap_valid", if_id_valid, 1'b1);

        // Reset mid-WAIT with a pending redirect, late done during reset is ignored.
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        tick;
        drive(1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000);
        #1;
        chk1("midwait_stall", fetch_stall, 1'b1);
        tick;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hDEAD);
        #1;
        chk1("midwait_rst_rd", imem_rd, 1'b0);
        chk1("midwait_rst_stall", fetch_stall, 1'b0);
        tick;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        chk1("post_rst_rd", imem_rd, 1'b1);
        chk16("post_rst_addr", imem_addr, 16'h0000);
        chk1("late_done_valid", if_id_valid, 1'b0);
        chk16("late_done_instr", if_id_instr, 16'h0800);
        tick;
        chk16("pend_dropped_pc", pc, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0102);
        tick;
        chk16("after_rst_pc", pc, 16'h0002);
        chk16("after_rst_instr", if_id_instr, 16'h0102);
        chk1("after_rst_valid", if_id_valid, 1'b1);

        // Randomized run: variable memory latency and random redirects against a transaction model.
        do_reset;
        begin
            int          lat = -1;
            logic [15:0] ea = 16'h0000, ei = 16'h0000, ep2 = 16'h0000, tgt = 16'h0000;
            logic        ev = 1'b0, redir_seen = 1'b0;
            logic        rv, d;
            logic [15:0] rp, rdat;
            for (int c = 0; c < 400; c++) begin
                chk1("rnd_valid", if_id_valid, ev);
                if (ev) begin
                    chk16("rnd_instr", if_id_instr, ei);
                    chk16("rnd_pc2", if_id_pc2, ep2);
                end
                chk16("rnd_pc", pc, ea);
                rv = ($urandom_range(0, 9) == 0);
                rp = 16'($urandom_range(0, 65535));
                if (lat < 0) lat = int'($urandom_range(0, 3));
                d = (lat == 0);
                rdat = mem_word(imem_addr);
                drive(1'b0, 1'b0, rv, rp, 1'b0, d, rdat);
                #1;
                chk1("rnd_rd", imem_rd, 1'b1);
                chk16("rnd_addr", imem_addr, ea);
                if (rv) begin
                    redir_seen = 1'b1;
                    tgt = rp & 16'hFFFE;
                end
                if (d) begin
                    lat = -1;
                    if (redir_seen) begin
                        ev = 1'b0;
                        ea = tgt;
                    end else begin
                        ev  = 1'b1;
                        ei  = mem_word(ea);
                        ep2 = ea + 16'd2;
                        ea  = ea + 16'd2;
                    end
                    redir_seen = 1'b0;
                end else begin
                    lat--;
                    ev = 1'b0;
                end
                tick;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage pipeline: PC register, instruction-memory request handshake, and the IF/ID pipeline latch.
- Directly upstream of the hazard unit.
  - Consumes its FD stall/NOP decisions and the branch/jump redirect.
  - Produces the IF/ID instruction and PC+2 that decode and the hazard unit read.
- Handles multi-cycle instruction memory, pending redirects during a memory wait, and HALT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, encoding injected into IF/ID on flush, hold-bubble or reset.
- PC_INC, 2, byte increment per sequential fetch.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low: state resets at a rising clk edge when rst==0.
- hold  input  1  hazard stall: freeze PC and IF/ID contents.
- flush  input  1  branch/jump taken: IF/ID becomes NOP next cycle.
- redirect_valid  input  1  PC load request (taken branch, jump, or EPC return).
- redirect_pc  input  16  target PC; bit 0 ignored, forced 0.
- halt_in  input  1  decode saw HALT; stop fetching.
- imem_rd  output  1  instruction read request.
- imem_addr  output  16  fetch address (= pc).
- imem_rdata  input  16  returned instruction, valid when imem_done==1.
- imem_done  input  1  read complete this cycle.
- imem_stall  input  1  memory busy; request must be held.
- pc  output  16  current fetch PC.
- if_id_instr  output  16  IF/ID instruction.
- if_id_pc2  output  16  IF/ID PC+2.
- if_id_valid  output  1  0 when IF/ID holds an injected NOP.
- fetch_stall  output  1  IF waiting on memory; hazard unit treats it as a stall source.
- halted  output  1  fetch permanently stopped.

Behaviour:
- Reset values:
  - pc=RESET_PC; state=RUN.
  - if_id_instr=NOP_INSTR; if_id_pc2=RESET_PC; if_id_valid=0.
  - imem_rd=0 in the reset cycle; halted=0; fetch_stall=0; pend_valid=0.
- States: RUN, WAIT, HALT. pend_valid/pend_pc is a one-entry redirect buffer.
- RUN:
  - imem_rd=1 unless hold.
  - If imem_done in the same cycle (single-cycle memory):
    - Latch imem_rdata into IF/ID.
    - Set if_id_pc2=pc+PC_INC and valid=1.
    - Set pc=pc+PC_INC.
  - Else enter WAIT.
- WAIT:
  - imem_rd stays 1 and imem_addr is held constant.
  - fetch_stall=1.
  - IF/ID outputs NOP (valid=0) each cycle, unless hold keeps the old contents.
  - On imem_done:
    - If pend_valid: discard the data, set pc=pend_pc, clear pend_valid, return to RUN.
    - Else: latch as in RUN and return to RUN.
- Redirect priority, highest first: reset > redirect/flush > hold > memory wait > sequential.
  - redirect_valid in RUN: pc=redirect_pc next cycle; IF/ID gets NOP.
  - redirect_valid in WAIT: store pend_pc; a later redirect before done overwrites it (last wins).
  - flush without redirect: IF/ID gets NOP; pc still advances.
- hold:
  - PC and IF/ID are unchanged; imem_rd=0 in RUN.
  - In WAIT, the outstanding request is kept alive.
  - flush or redirect override hold for the IF/ID contents.
- halt_in:
  - Move to HALT after any outstanding request completes; the completing data is dropped.
  - In HALT: imem_rd=0, halted=1, IF/ID=NOP, pc frozen.
  - HALT is exited only by reset.
- PC arithmetic is modulo 2^16: 16'hFFFE+2 wraps to 16'h0000. No error is raised.
- rst==0 mid-WAIT:
  - Abandon the request; drop any pending redirect.
  - A late imem_done after reset, while imem_rd=0, is ignored.
- imem_done while imem_rd==0 is ignored in all states.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (valid instructions latched) and perf_stall_cnt[31:0] (cycles with fetch_stall or hold).
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: neither the ports nor the counter logic exist; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSTR and RESET_PC constants.
  - fetch_state_t enum (RUN, WAIT, HALT).
  - A 16-bit instruction word typedef, reused by decode and the hazard unit.
- One sub-module if_id_reg: the IF/ID latch with load / hold / inject-NOP controls and synchronous active-low reset.
- fetch_stage contains the FSM, PC and pending-redirect buffer.

Test Plan:
- Reset, then 4 cycles with single-cycle memory returning 16'h1111..16'h4444:
  - pc goes 0,2,4,6,8.
  - if_id_instr follows one cycle behind; valid=1.
- imem_done delayed 3 cycles at pc=0x0010:
  - fetch_stall=1 and if_id_valid=0 for 3 cycles.
  - imem_addr stays 0x0010; pc reaches 0x0012 after done.
- redirect_valid with redirect_pc=0x0100 during WAIT, then done:
  - Returned data is discarded.
  - The next imem_addr is 0x0100 and no stale instruction appears in IF/ID.
- hold for 2 cycles with IF/ID=16'hABCD:
  - IF/ID and pc are unchanged; imem_rd=0.
  - Asserting flush with hold gives IF/ID=16'h0800 and valid=0.
- halt_in asserted at pc=0x0020:
  - halted=1 next cycle; imem_rd=0 forever.
  - rst=0 for one edge restores pc=0 and halted=0.
- pc=0xFFFE sequential fetch wraps pc to 0x0000; rst=0 mid-WAIT, then a late imem_done is ignored.
